ex_mdu: RTL and testbench
=========================

# ex_mdu

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It owns the architectural HI/LO registers and runs MULT/MULTU as a fixed-latency multiply and DIV/DIVU as a one-bit-per-cycle restoring divide. While an operation is in flight it holds the EX stage through `stallreq`. It generalises the single-cycle EX datapath with parametrised width and latency, multi-cycle sequencing, and flush abort.

## Interface
- `WIDTH`, 32: operand width. HI and LO are each `WIDTH`.
- `MUL_CYCLES`, 2: cycles spent in MUL state; must be ≥1.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  abort current/offered op, no HI/LO side effect except as stated below.
- `op_valid`  in  1  the instruction in EX is an MDU op.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored (treated as op_valid=0).
- `src_a`  in  WIDTH  rs value (dividend / multiplicand / MTHI-MTLO data).
- `src_b`  in  WIDTH  rt value (divisor / multiplier).
- `stallreq`  out  1  hold EX and earlier stages (feeds stall controller as `stallreq_from_ex`-class request).
- `busy`  out  1  state is MUL or DIV.
- `hi`, `lo`  out  WIDTH  architectural HI/LO.
- `div_by_zero`  out  1  one-cycle pulse in DONE when a divide had `src_b`=0.

## Operation
- States: IDLE, MUL, DIV, DONE. Reset → IDLE; hi=lo=0; busy=0; div_by_zero=0; stallreq=0.
- IDLE, op_valid, no flush:
  - MULT/MULTU: capture operands and signedness → MUL; counter=MUL_CYCLES-1.
  - DIV/DIVU with src_b≠0: capture |a|, |b| (signed) or raw (unsigned), sign flags → DIV; counter=WIDTH-1.
  - DIV/DIVU with src_b=0: → DONE directly; HI/LO unchanged; div_by_zero=1 in DONE.
  - MTHI/MTLO: write hi/lo at this edge; stay IDLE; no stall.
- MUL: product = 2·WIDTH-bit signed or unsigned product of captured operands. Counter decrements; at counter=0, write hi=product[2W-1:W], lo=product[W-1:0] → DONE.
- DIV: restoring step per cycle — shift {rem,quot} left 1; if rem ≥ divisor, subtract and set quot LSB. At counter=0, write the final values → DONE:
  - lo = quotient, negated if signs differ (signed only);
  - hi = remainder, carrying the dividend's sign (signed only).
  - Overflow case −2^(W−1)/−1: lo=0x8000_0000, hi=0 (W=32); no exception.
- DONE: op_valid ignored (it is the same held instruction, now released). → IDLE next cycle.
- stallreq = op_valid & op∈{MULT,MULTU,DIV,DIVU} & state≠DONE & ~flush (combinational). It is also 0 during rst.
- flush (any state): next state IDLE; the partial result is discarded, and HI/LO are not written at that edge. In DONE, HI/LO were already written and are kept.
- Simultaneous rst and flush: rst wins.

## Timing
- Op offered in IDLE at cycle T.
- MULT: stallreq 1 for T..T+MUL_CYCLES. DONE at T+MUL_CYCLES+1, where hi/lo show the new value and stallreq=0. IDLE at T+MUL_CYCLES+2.
- DIV: stallreq 1 for T..T+WIDTH. DONE at T+WIDTH+1. IDLE at T+WIDTH+2.
- Div-by-zero: stallreq 1 at T only. DONE at T+1 with div_by_zero=1.
- MTHI/MTLO: new hi/lo visible at T+1. stallreq never asserted.
- Back-to-back: the next MDU op can start in the cycle after DONE. No gaps other than the DONE cycle.
- busy is registered from state. div_by_zero is combinational from the DONE state plus a registered dz flag.

## Test plan
- Reset, then check hi=lo=0, stallreq=0. Apply MTHI 0x1234_5678, then MTLO 0xDEAD_BEEF → hi/lo match one cycle later, no stall.
- MULT −3 × 7 (0xFFFF_FFFD, 0x7), MUL_CYCLES=2 → stallreq high 3 cycles, then hi=0xFFFF_FFFF, lo=0xFFFF_FFEB. MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → hi=0xFFFF_FFFE, lo=0x0000_0001.
- DIV −7 / 2 → after 33 stall cycles, lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU 100 / 7 → lo=14, hi=2. DIV 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- DIV 5 / 0 with hi/lo preloaded to 0xAAAA_AAAA → one stall cycle, div_by_zero pulse, hi/lo unchanged.
- DIVU issued, then flush asserted at cycle T+10 → IDLE next cycle, stallreq drops, hi/lo hold their prior values. A MULT 2×3 then issued → lo=6.
- rst asserted mid-DIV → next cycle IDLE, hi=lo=0, busy=0. Also a randomized MULT/DIV stream checked against a reference model, with stallreq cycle counts asserted.

Source files
------------

// File: rtl/ex_mdu.sv
// ex_mdu: execute-stage multiply/divide unit.
//
// Owns the architectural HI/LO registers. MULT/MULTU run as a fixed-latency
// multiply (MUL_CYCLES cycles in MUL). DIV/DIVU run as a one-bit-per-cycle
// restoring divide (WIDTH cycles in DIV). MTHI/MTLO write HI/LO directly from
// IDLE. While a multi-cycle op is in flight the EX stage is held via stallreq.
//
// Handshake: the pipeline presents an MDU op with op_valid=1 and keeps it
// (same instruction, same operands) for as long as stallreq=1. The cycle in
// which stallreq drops with op_valid still high is the DONE cycle: HI/LO
// already show the result and the instruction may leave EX. flush kills the
// op in any state without writing HI/LO.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   flush           abort the current/offered op
//   op_valid, op    MDU op presented in EX (000 MULT, 001 MULTU, 010 DIV,
//                   011 DIVU, 100 MTHI, 101 MTLO, 11x ignored)
//   src_a, src_b    rs / rt operand values
//   stallreq        hold EX and earlier stages
//   busy            registered: unit is in MUL or DIV
//   hi, lo          architectural HI/LO
//   div_by_zero     one-cycle pulse in DONE after a divide by zero
module ex_mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             stallreq,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // FSM state; kept as a named enum so checkers can bind to dut.state.
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t state, state_next;

  // Op decode
  logic is_mul, is_div, is_mthi, is_mtlo, op_signed, b_zero;
  assign is_mul    = op_valid && (op == OP_MULT || op == OP_MULTU);
  assign is_div    = op_valid && (op == OP_DIV  || op == OP_DIVU);
  assign is_mthi   = op_valid && (op == OP_MTHI);
  assign is_mtlo   = op_valid && (op == OP_MTLO);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign b_zero    = (src_b == '0);

  // Datapath registers. a_q/b_q hold multiplicand/multiplier in MUL and
  // quotient-in-progress/divisor in DIV (the dividend is shifted out of a_q
  // while quotient bits are shifted in).
  logic [WIDTH-1:0] a_q, b_q, rem_q;
  logic             sgn_q, neg_q, neg_r, dz_q;
  logic [CW-1:0]    cnt_q;

  // Magnitudes for signed divide; -(-2^(W-1)) wraps to itself, which is the
  // correct unsigned magnitude.
  logic [WIDTH-1:0] abs_a, abs_b;
  assign abs_a = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
  assign abs_b = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;

  // Multiply: sign- or zero-extend to 2W, low 2W bits of the product are exact.
  logic [2*WIDTH-1:0] ext_a, ext_b, product;
  assign ext_a   = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
  assign ext_b   = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
  assign product = ext_a * ext_b;

  // One restoring divide step. rem_q < divisor always, so the shifted
  // remainder needs one extra bit for the compare only.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff, rem_n, quot_n;
  logic             rem_ge;
  assign rem_sh   = {rem_q, a_q[WIDTH-1]};
  assign rem_ge   = (rem_sh >= {1'b0, b_q});
  assign rem_diff = rem_sh[WIDTH-1:0] - b_q;
  assign rem_n    = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
  assign quot_n   = {a_q[WIDTH-2:0], rem_ge};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (is_mul)      state_next = S_MUL;
        else if (is_div) state_next = b_zero ? S_DONE : S_DIV;
      end
      S_MUL:   if (cnt_q == '0) state_next = S_DONE;
      S_DIV:   if (cnt_q == '0) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  // Outputs decoded from state
  always_comb begin
    stallreq    = (is_mul || is_div) && (state != S_DONE) && !flush && !rst;
    div_by_zero = (state == S_DONE) && dz_q;
  end

  // Datapath and HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      hi    <= '0;
      lo    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      rem_q <= '0;
      sgn_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz_q  <= 1'b0;
      cnt_q <= '0;
      busy  <= 1'b0;
    end else begin
      busy <= (state_next == S_MUL) || (state_next == S_DIV);
      dz_q <= (state == S_IDLE) && !flush && is_div && b_zero;
      if (!flush) begin
        case (state)
          S_IDLE: begin
            if (is_mul) begin
              a_q   <= src_a;
              b_q   <= src_b;
              sgn_q <= op_signed;
              cnt_q <= CW'(MUL_CYCLES - 1);
            end else if (is_div && !b_zero) begin
              a_q   <= abs_a;
              b_q   <= abs_b;
              rem_q <= '0;
              neg_q <= op_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
              neg_r <= op_signed && src_a[WIDTH-1];
              cnt_q <= CW'(WIDTH - 1);
            end
            if (is_mthi) hi <= src_a;
            if (is_mtlo) lo <= src_a;
          end
          S_MUL: begin
            if (cnt_q == '0) begin
              hi <= product[2*WIDTH-1:WIDTH];
              lo <= product[WIDTH-1:0];
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          S_DIV: begin
            a_q   <= quot_n;
            rem_q <= rem_n;
            if (cnt_q == '0) begin
              // Quotient sign from operand signs, remainder follows dividend.
              lo <= neg_q ? -quot_n : quot_n;
              hi <= neg_r ? -rem_n  : rem_n;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Testbench for ex_mdu: directed vectors with literal expectations, a small
// arithmetic reference model for HI/LO, and a per-cycle compare process.
module tb_ex_mdu;

  localparam int W  = 32;
  localparam int MC = 2;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, flush, op_valid;
  logic [2:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         stallreq, busy, div_by_zero;
  logic [W-1:0] hi, lo;

  ex_mdu #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op(op),
    .src_a(src_a), .src_b(src_b), .stallreq(stallreq), .busy(busy),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  // Scoreboard state
  int           n_chk = 0;
  int           n_err = 0;
  bit           chk_en = 1'b0;
  logic [W-1:0] exp_hi, exp_lo;
  logic         exp_stall, exp_busy, exp_dz;
  int           stall_cnt = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: architectural {hi,lo} after an op, from plain arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi0,
                                        input logic [31:0] lo0);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'h0) return {hi0, lo0};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      3'd3: begin
        if (b == 32'h0) return {hi0, lo0};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return {hi0, lo0};
    endcase
  endfunction

  // Compare process: every cycle once checking is enabled.
  always @(negedge clk) begin
    if (stallreq === 1'b1) stall_cnt++;
    if (chk_en) begin
      chk("hi", hi, exp_hi);
      chk("lo", lo, exp_lo);
      chk("stallreq", stallreq, exp_stall);
      chk("busy", busy, exp_busy);
      chk("div_by_zero", div_by_zero, exp_dz);
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step();
    op_valid  = 1'b0;
    flush     = 1'b0;
    exp_stall = 1'b0;
    exp_busy  = 1'b0;
    exp_dz    = 1'b0;
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] data);
    step();
    op_valid = 1'b1; op = o; src_a = data; src_b = 32'h0;
    exp_stall = 1'b0; exp_busy = 1'b0; exp_dz = 1'b0;
    step();
    op_valid = 1'b0;
    if (o == 3'd4) exp_hi = data;
    else           exp_lo = data;
    @(negedge clk); #1;
    chk(o == 3'd4 ? "mthi_value" : "mtlo_value", o == 3'd4 ? hi : lo, data);
  endtask

  // Present an op, hold it while stalled, then check the DONE cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit lit, input logic [31:0] lhi, input logic [31:0] llo);
    logic [63:0] r;
    int lat;
    bit dz;
    exp_q.push_back(model(o, a, b, exp_hi, exp_lo));
    dz  = o[1] && (b == 32'h0);
    lat = o[1] ? (dz ? 0 : W) : MC;
    for (int c = 0; c <= lat; c++) begin
      step();
      op_valid = 1'b1; op = o; src_a = a; src_b = b; flush = 1'b0;
      exp_stall = 1'b1; exp_busy = (c > 0); exp_dz = 1'b0;
      if (c == 0) stall_cnt = 0;
    end
    step();
    r = exp_q.pop_front();
    exp_hi = r[63:32]; exp_lo = r[31:0];
    exp_stall = 1'b0; exp_busy = 1'b0; exp_dz = dz;
    @(negedge clk); #1;
    chk("stall_cycles", 64'(stall_cnt), 64'(lat + 1));
    if (lit) begin
      chk("lit_hi", hi, lhi);
      chk("lit_lo", lo, llo);
    end
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
    exp_hi = '0; exp_lo = '0; exp_stall = 1'b0; exp_busy = 1'b0; exp_dz = 1'b0;
    step();
    // Reset held with an op offered: stallreq must stay low.
    step();
    op_valid = 1'b1; op = 3'd0;
    chk_en = 1'b1;
    step();
    rst = 1'b0; op_valid = 1'b0;

    // Ignored opcode 110: no stall, no state change.
    step();
    op_valid = 1'b1; op = 3'b110; src_a = 32'h5555_5555;
    idle();

    mt(3'd4, 32'h1234_5678);
    mt(3'd5, 32'hDEAD_BEEF);

    run_op(3'd0, 32'hFFFF_FFFD, 32'h7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    // Back-to-back: next op starts right after DONE.
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
    idle();
    run_op(3'd2, 32'hFFFF_FFF9, 32'h2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(3'd3, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000);
    idle();

    // Divide by zero leaves preloaded HI/LO alone.
    mt(3'd4, 32'hAAAA_AAAA);
    mt(3'd5, 32'hAAAA_AAAA);
    run_op(3'd2, 32'd5, 32'd0, 1'b1, 32'hAAAA_AAAA, 32'hAAAA_AAAA);
    idle();

    // Flush at T+10 of a DIVU.
    for (int c = 0; c < 10; c++) begin
      step();
      op_valid = 1'b1; op = 3'd3; src_a = 32'd1000; src_b = 32'd3;
      exp_stall = 1'b1; exp_busy = (c > 0);
    end
    step();
    flush = 1'b1; exp_stall = 1'b0; exp_busy = 1'b1;
    step();
    flush = 1'b0; op_valid = 1'b0; exp_busy = 1'b0;
    @(negedge clk); #1;
    chk("flush_lo_kept", lo, 32'hAAAA_AAAA);
    chk("flush_busy", busy, 1'b0);
    run_op(3'd0, 32'd2, 32'd3, 1'b1, 32'h0, 32'd6);
    idle();

    // Reset in the middle of a DIV.
    for (int c = 0; c < 6; c++) begin
      step();
      op_valid = 1'b1; op = 3'd2; src_a = 32'd1000; src_b = 32'd7;
      exp_stall = 1'b1; exp_busy = (c > 0);
    end
    step();
    rst = 1'b1; exp_stall = 1'b0; exp_busy = 1'b1;
    step();
    rst = 1'b0; op_valid = 1'b0;
    exp_hi = '0; exp_lo = '0; exp_busy = 1'b0;
    @(negedge clk); #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);

    // Mixed stream checked against the model.
    for (int i = 0; i < 8; i++) begin
      idle();
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op(ro, ra, rb, 1'b0, 32'h0, 32'h0);
    end
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
